// File: rtl/VX_gpu_pkg.sv
// Shared GPU-core types for the fetch path.
//   fetch_ctx_t  : warp context parked while its I-cache read is outstanding
//   fetch_beat_t : one instruction beat handed to decode (context + word + warp id)
// The core-wide sizes below set the widths of these types; the fetch stage
// parameters default to the same values.
package VX_gpu_pkg;

    localparam int NUM_WARPS   = 4;
    localparam int NUM_THREADS = 4;
    localparam int XLEN        = 32;
    localparam int UUID_WIDTH  = 44;
    localparam int NW_WIDTH    = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;

    typedef struct packed {
        logic [XLEN-1:0]        pc;
        logic [NUM_THREADS-1:0] tmask;
        logic [UUID_WIDTH-1:0]  uuid;
    } fetch_ctx_t;

    typedef struct packed {
        fetch_ctx_t            ctx;
        logic [31:0]           instr;
        logic [NW_WIDTH-1:0]   wid;
    } fetch_beat_t;

endpackage

// File: rtl/vx_fetch_skid.sv
// Two-entry valid/ready elastic buffer.
//   clk, reset            : clock, synchronous active-high reset (control only)
//   valid_in/ready_in     : upstream handshake; ready_in depends only on occupancy
//   data_in               : DATAW-bit payload
//   valid_out/ready_out   : downstream handshake
//   data_out              : head entry, stable while valid_out & ~ready_out
// Two entries let the buffer accept and emit one beat per cycle while
// ready_in stays a pure register output (no combinational path from ready_out).
module vx_fetch_skid #(
    parameter int DATAW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    output logic             ready_in,
    input  logic [DATAW-1:0] data_in,
    output logic             valid_out,
    input  logic             ready_out,
    output logic [DATAW-1:0] data_out
);

    logic [DATAW-1:0] mem [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic             push;
    logic             pop;

    assign ready_in  = (count != 2'd2);
    assign valid_out = (count != 2'd0);
    assign data_out  = mem[rd_ptr];
    assign push      = valid_in & ready_in;
    assign pop       = valid_out & ready_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= data_in;
    end

endmodule

// File: rtl/vx_fetch_stage.sv
// Instruction-fetch stage between the warp scheduler and decode.
//   clk, reset                 : clock, synchronous active-high reset
//   sched_*                    : scheduled warp {wid, tmask, pc, uuid}, valid/ready
//   icache_req_*               : word-address request tagged with the warp id
//   icache_rsp_*               : instruction word returned with its warp id tag
//   fetch_*                    : re-joined {context, instr} beat to decode, valid/ready
//   busy                       : registered; any fetch pending or buffered last cycle
// At most one fetch per warp is outstanding (pending[] bit); the warp context
// is parked in a per-warp table and rejoined with the response by tag, so
// responses may return out of order across warps.
module vx_fetch_stage #(
    parameter int NUM_WARPS   = VX_gpu_pkg::NUM_WARPS,
    parameter int NUM_THREADS = VX_gpu_pkg::NUM_THREADS,
    parameter int XLEN        = VX_gpu_pkg::XLEN,
    parameter int UUID_WIDTH  = VX_gpu_pkg::UUID_WIDTH,
    localparam int NW_WIDTH   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   sched_valid,
    output logic                   sched_ready,
    input  logic [NW_WIDTH-1:0]    sched_wid,
    input  logic [NUM_THREADS-1:0] sched_tmask,
    input  logic [XLEN-1:0]        sched_pc,
    input  logic [UUID_WIDTH-1:0]  sched_uuid,

    output logic                   icache_req_valid,
    input  logic                   icache_req_ready,
    output logic [XLEN-3:0]        icache_req_addr,
    output logic [NW_WIDTH-1:0]    icache_req_tag,

    input  logic                   icache_rsp_valid,
    output logic                   icache_rsp_ready,
    input  logic [31:0]            icache_rsp_data,
    input  logic [NW_WIDTH-1:0]    icache_rsp_tag,

    output logic                   fetch_valid,
    input  logic                   fetch_ready,
    output logic [NW_WIDTH-1:0]    fetch_wid,
    output logic [NUM_THREADS-1:0] fetch_tmask,
    output logic [XLEN-1:0]        fetch_pc,
    output logic [UUID_WIDTH-1:0]  fetch_uuid,
    output logic [31:0]            fetch_instr,

    output logic                   busy
);

    import VX_gpu_pkg::*;

    fetch_ctx_t           ctx_table [NUM_WARPS];
    logic [NUM_WARPS-1:0] pending;
    logic                 req_blocked;
    logic                 req_fire;
    logic                 rsp_fire;
    fetch_ctx_t           req_ctx;
    fetch_beat_t          rsp_beat;
    fetch_beat_t          out_beat;
    logic                 busy_p1;

    // ---- Request: scheduler -> I-cache (combinational) ----
    // A warp with a fetch outstanding is held off until its response is
    // accepted; the clear lands at the clock edge, so a request for the same
    // warp in the response cycle is refused and goes through one cycle later.
    assign req_blocked      = pending[sched_wid];
    assign icache_req_valid = sched_valid & ~req_blocked;
    assign sched_ready      = icache_req_ready & ~req_blocked;
    assign req_fire         = sched_valid & sched_ready;
    assign icache_req_addr  = sched_pc[XLEN-1:2];
    assign icache_req_tag   = sched_wid;

    assign req_ctx.pc    = sched_pc;
    assign req_ctx.tmask = sched_tmask;
    assign req_ctx.uuid  = sched_uuid;

    // Context table: one write port (request) and one read port (response),
    // so a request for one warp and a response for another never interact.
    always_ff @(posedge clk) begin
        if (req_fire) ctx_table[sched_wid] <= req_ctx;
    end

    // ---- Response: I-cache -> output buffer ----
    assign rsp_fire       = icache_rsp_valid & icache_rsp_ready;
    assign rsp_beat.ctx   = ctx_table[icache_rsp_tag];
    assign rsp_beat.instr = icache_rsp_data;
    assign rsp_beat.wid   = icache_rsp_tag;

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (rsp_fire) pending[icache_rsp_tag] <= 1'b0;
            if (req_fire) pending[sched_wid]      <= 1'b1;
        end
    end

    vx_fetch_skid #(
        .DATAW ($bits(fetch_beat_t))
    ) u_skid (
        .clk       (clk),
        .reset     (reset),
        .valid_in  (icache_rsp_valid),
        .ready_in  (icache_rsp_ready),
        .data_in   (rsp_beat),
        .valid_out (fetch_valid),
        .ready_out (fetch_ready),
        .data_out  (out_beat)
    );

    // ---- Output: buffer head -> decode ----
    assign fetch_wid   = out_beat.wid;
    assign fetch_tmask = out_beat.ctx.tmask;
    assign fetch_pc    = out_beat.ctx.pc;
    assign fetch_uuid  = out_beat.ctx.uuid;
    assign fetch_instr = out_beat.instr;

    always_ff @(posedge clk) begin
        if (reset) busy_p1 <= 1'b0;
        else       busy_p1 <= (|pending) | fetch_valid;
    end
    assign busy = busy_p1;

    // Protocol checks on accepted transfers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (req_fire) begin
                assert (sched_pc[1:0] == 2'b00);
                assert (int'(sched_wid) < NUM_WARPS);
            end
            if (rsp_fire) begin
                assert (pending[icache_rsp_tag]);
            end
        end
    end

endmodule

// File: tb/tb_vx_fetch_stage.sv
module tb_vx_fetch_stage;

    logic        clk;
    logic        reset;
    logic        sched_valid;
    logic        sched_ready;
    logic [1:0]  sched_wid;
    logic [3:0]  sched_tmask;
    logic [31:0] sched_pc;
    logic [43:0] sched_uuid;
    logic        icache_req_valid;
    logic        icache_req_ready;
    logic [29:0] icache_req_addr;
    logic [1:0]  icache_req_tag;
    logic        icache_rsp_valid;
    logic        icache_rsp_ready;
    logic [31:0] icache_rsp_data;
    logic [1:0]  icache_rsp_tag;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [1:0]  fetch_wid;
    logic [3:0]  fetch_tmask;
    logic [31:0] fetch_pc;
    logic [43:0] fetch_uuid;
    logic [31:0] fetch_instr;
    logic        busy;

    vx_fetch_stage dut (
        .clk              (clk),
        .reset            (reset),
        .sched_valid      (sched_valid),
        .sched_ready      (sched_ready),
        .sched_wid        (sched_wid),
        .sched_tmask      (sched_tmask),
        .sched_pc         (sched_pc),
        .sched_uuid       (sched_uuid),
        .icache_req_valid (icache_req_valid),
        .icache_req_ready (icache_req_ready),
        .icache_req_addr  (icache_req_addr),
        .icache_req_tag   (icache_req_tag),
        .icache_rsp_valid (icache_rsp_valid),
        .icache_rsp_ready (icache_rsp_ready),
        .icache_rsp_data  (icache_rsp_data),
        .icache_rsp_tag   (icache_rsp_tag),
        .fetch_valid      (fetch_valid),
        .fetch_ready      (fetch_ready),
        .fetch_wid        (fetch_wid),
        .fetch_tmask      (fetch_tmask),
        .fetch_pc         (fetch_pc),
        .fetch_uuid       (fetch_uuid),
        .fetch_instr      (fetch_instr),
        .busy             (busy)
    );

    typedef struct {
        logic [1:0]  wid;
        logic [31:0] pc;
        logic [3:0]  tmask;
        logic [43:0] uuid;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h required %0h", name, act, req);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every beat accepted by decode is compared with the head of the queue.
    always @(negedge clk) begin
        if (!reset && fetch_valid === 1'b1 && fetch_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected beat", {fetch_wid, fetch_pc}, 128'hDEAD);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("beat {wid,pc,tmask,uuid,instr}",
                      {fetch_wid, fetch_pc, fetch_tmask, fetch_uuid, fetch_instr},
                      {e.wid, e.pc, e.tmask, e.uuid, e.instr});
            end
        end
    end

    // Issue one scheduled warp; returns at posedge+1 after it fired.
    task automatic issue(input logic [1:0] wid, input logic [31:0] pc,
                         input logic [3:0] tmask, input logic [43:0] uuid);
        int n = 0;
        bit ok = 0;
        sched_valid = 1'b1; sched_wid = wid; sched_pc = pc;
        sched_tmask = tmask; sched_uuid = uuid; icache_req_ready = 1'b1;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (sched_ready === 1'b1) ok = 1;
            else begin n++; @(posedge clk); end
        end
        if (!ok) check("issue timeout", 0, 1);
        @(posedge clk);
        #1;
        sched_valid = 1'b0;
    endtask

    // Present one I-cache response; the expected beat is queued as it fires.
    task automatic respond(input logic [1:0] tag, input logic [31:0] data,
                           input logic [31:0] pc, input logic [3:0] tmask,
                           input logic [43:0] uuid);
        int n = 0;
        bit ok = 0;
        icache_rsp_valid = 1'b1; icache_rsp_tag = tag; icache_rsp_data = data;
        while (!ok && n < 50) begin
            @(negedge clk);
            if (icache_rsp_ready === 1'b1) ok = 1;
            else begin n++; @(posedge clk); end
        end
        if (ok) exp_q.push_back('{wid: tag, pc: pc, tmask: tmask, uuid: uuid, instr: data});
        else check("respond timeout", 0, 1);
        @(posedge clk);
        #1;
        icache_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit blocked;
        bit drained;
        reset = 1'b1;
        sched_valid = 0; sched_wid = 0; sched_tmask = 0; sched_pc = 0; sched_uuid = 0;
        icache_req_ready = 1'b1; icache_rsp_valid = 0; icache_rsp_data = 0; icache_rsp_tag = 0;
        fetch_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset fetch_valid", fetch_valid, 0);
        check("reset busy", busy, 0);
        for (int w = 0; w < 4; w++) begin
            sched_wid = 2'(w);
            #1;
            check("reset sched_ready", sched_ready, 1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single fetch
        sched_valid = 1'b1; sched_wid = 2'd0; sched_pc = 32'h8000_0000;
        sched_tmask = 4'h1; sched_uuid = 44'h1;
        @(negedge clk);
        check("single req_valid", icache_req_valid, 1);
        check("single req_addr", icache_req_addr, 30'h2000_0000);
        check("single req_tag", icache_req_tag, 2'd0);
        tick();
        sched_valid = 1'b0;
        tick();
        respond(2'd0, 32'h0000_0013, 32'h8000_0000, 4'h1, 44'h1);
        @(negedge clk);
        check("single rsp->fetch latency", fetch_valid, 1);
        check("single busy", busy, 1);
        tick();

        // Per-warp blocking
        issue(2'd1, 32'h40, 4'h3, 44'h2);
        sched_valid = 1'b1; sched_wid = 2'd1; sched_pc = 32'h44; sched_tmask = 4'h3; sched_uuid = 44'h3;
        blocked = 1;
        repeat (3) begin
            @(negedge clk);
            blocked = blocked & !sched_ready & !icache_req_valid;
            tick();
        end
        check("blocked while pending", blocked, 1);
        icache_rsp_valid = 1'b1; icache_rsp_tag = 2'd1; icache_rsp_data = 32'hAA;
        @(negedge clk);
        check("refused in rsp cycle", sched_ready, 0);
        exp_q.push_back('{wid: 2'd1, pc: 32'h40, tmask: 4'h3, uuid: 44'h2, instr: 32'hAA});
        tick();
        icache_rsp_valid = 1'b0;
        @(negedge clk);
        check("accepted cycle after rsp", sched_ready, 1);
        tick();
        sched_valid = 1'b0;
        respond(2'd1, 32'hBB, 32'h44, 4'h3, 44'h3);

        // Out-of-order responses
        issue(2'd0, 32'h100, 4'h1, 44'h10);
        issue(2'd1, 32'h200, 4'h2, 44'h11);
        issue(2'd2, 32'h300, 4'h4, 44'h12);
        issue(2'd3, 32'h400, 4'h8, 44'h13);
        respond(2'd2, 32'h1002, 32'h300, 4'h4, 44'h12);
        respond(2'd0, 32'h1000, 32'h100, 4'h1, 44'h10);
        respond(2'd3, 32'h1003, 32'h400, 4'h8, 44'h13);
        respond(2'd1, 32'h1001, 32'h200, 4'h2, 44'h11);
        repeat (3) tick();

        // Back-pressure
        fetch_ready = 1'b0;
        issue(2'd0, 32'h500, 4'h1, 44'h40);
        issue(2'd1, 32'h600, 4'h3, 44'h41);
        issue(2'd2, 32'h700, 4'h7, 44'h42);
        respond(2'd0, 32'h2000, 32'h500, 4'h1, 44'h40);
        respond(2'd1, 32'h2001, 32'h600, 4'h3, 44'h41);
        fork
            respond(2'd2, 32'h2002, 32'h700, 4'h7, 44'h42);
            begin
                @(negedge clk);
                check("rsp_ready low when full", icache_rsp_ready, 0);
                check("head held under stall", fetch_pc, 32'h500);
                repeat (3) @(posedge clk);
                #1;
                check("head still held", {fetch_valid, fetch_pc}, {1'b1, 32'h500});
                fetch_ready = 1'b1;
                drained = 1;
                repeat (3) begin
                    @(negedge clk);
                    drained = drained & fetch_valid;
                end
                check("drain 1 beat/cycle", drained, 1);
            end
        join
        repeat (2) tick();

        // Simultaneous request (wid 2) and response (wid 3)
        issue(2'd3, 32'h3000, 4'hF, 44'h30);
        fork
            issue(2'd2, 32'h2000, 4'h5, 44'h20);
            respond(2'd3, 32'h33, 32'h3000, 4'hF, 44'h30);
        join
        respond(2'd2, 32'h22, 32'h2000, 4'h5, 44'h20);
        repeat (2) tick();

        // Reset mid-flight
        fetch_ready = 1'b0;
        issue(2'd0, 32'h900, 4'h1, 44'h50);
        issue(2'd1, 32'hA00, 4'h2, 44'h51);
        issue(2'd2, 32'hB00, 4'h4, 44'h52);
        respond(2'd2, 32'h55, 32'hB00, 4'h4, 44'h52);
        @(negedge clk);
        check("pre-reset busy", busy, 1);
        check("pre-reset beat buffered", fetch_valid, 1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("post-reset fetch_valid", fetch_valid, 0);
        check("post-reset busy", busy, 0);
        for (int w = 0; w < 4; w++) begin
            sched_wid = 2'(w);
            icache_req_ready = 1'b1;
            #1;
            check("post-reset sched_ready rdy=1", sched_ready, 1);
            icache_req_ready = 1'b0;
            #1;
            check("post-reset sched_ready rdy=0", sched_ready, 0);
        end
        icache_req_ready = 1'b1;
        fetch_ready = 1'b1;
        tick();
        issue(2'd0, 32'hC00, 4'h1, 44'h60);
        respond(2'd0, 32'h77, 32'hC00, 4'h1, 44'h60);
        repeat (3) tick();
        check("scoreboard drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
